// File: rtl/fifo_byte_packer_if.sv
// Bundles the FIFO read port and the packed-word output stream of fifo_byte_packer.
// master = the packer side, slave = the FIFO / downstream side.
interface fifo_byte_packer_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NBYTES = 4
);
   logic                     fifo_empty;
   logic [DATA_W-1:0]        fifo_rd_data;
   logic                     fifo_rd_en;
   logic [DATA_W*NBYTES-1:0] out_data;
   logic                     out_valid;
   logic                     out_ready;

   modport master (
      input  fifo_empty,
      input  fifo_rd_data,
      input  out_ready,
      output fifo_rd_en,
      output out_data,
      output out_valid
   );

   modport slave (
      output fifo_empty,
      output fifo_rd_data,
      output out_ready,
      input  fifo_rd_en,
      input  out_data,
      input  out_valid
   );
endinterface

// File: rtl/fifo_byte_packer.sv
// Drains a 1-cycle-latency byte FIFO and packs NBYTES bytes per word onto a valid/ready stream.
// Optional macro PACK_MSB_FIRST_EN: first byte lands in the most significant lane.
module fifo_byte_packer #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NBYTES = 4,
   parameter int unsigned CNT_W  = 16,
   localparam int unsigned BC_W  = $clog2(NBYTES + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   fifo_byte_packer_if.master bus,
   output logic [BC_W-1:0]  byte_cnt,
   output logic [CNT_W-1:0] word_cnt
);
   localparam int unsigned W = DATA_W * NBYTES;

   typedef enum logic [0:0] {StFill, StHold} state_e;

   state_e           state_q, state_d;
   logic [BC_W-1:0]  issued_q, issued_d;
   logic [BC_W-1:0]  byte_cnt_q, byte_cnt_d;
   logic             pend_q;
   logic [W-1:0]     data_q, data_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic             rd_en;
   int unsigned      lane;

   always_comb begin
      state_d    = state_q;
      issued_d   = issued_q;
      byte_cnt_d = byte_cnt_q;
      data_d     = data_q;
      valid_d    = valid_q;
      word_cnt_d = word_cnt_q;
      lane       = 0;

      // Never read an empty FIFO, never request more than NBYTES bytes per word.
      rd_en = (state_q == StFill) && !bus.fifo_empty && (issued_q < BC_W'(NBYTES));
      if (rd_en) begin
         issued_d = issued_q + BC_W'(1);
      end

      unique case (state_q)
         StFill: begin
            if (pend_q) begin
`ifdef PACK_MSB_FIRST_EN
               lane = NBYTES - 1 - int'(unsigned'(byte_cnt_q));
`else
               lane = int'(unsigned'(byte_cnt_q));
`endif
               data_d[lane*DATA_W +: DATA_W] = bus.fifo_rd_data;
               byte_cnt_d = byte_cnt_q + BC_W'(1);
               if (byte_cnt_q == BC_W'(NBYTES - 1)) begin
                  valid_d = 1'b1;
                  state_d = StHold;
               end
            end
         end
         StHold: begin
            if (bus.out_ready) begin
               valid_d    = 1'b0;
               byte_cnt_d = '0;
               issued_d   = '0;
               word_cnt_d = word_cnt_q + CNT_W'(1);
               state_d    = StFill;
            end
         end
         default: state_d = StFill;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StFill;
         issued_q   <= '0;
         byte_cnt_q <= '0;
         pend_q     <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         word_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         issued_q   <= issued_d;
         byte_cnt_q <= byte_cnt_d;
         pend_q     <= rd_en;
         data_q     <= data_d;
         valid_q    <= valid_d;
         word_cnt_q <= word_cnt_d;
      end
   end

   assign bus.fifo_rd_en = rd_en;
   assign bus.out_data   = data_q;
   assign bus.out_valid  = valid_q;
   assign byte_cnt       = byte_cnt_q;
   assign word_cnt       = word_cnt_q;
endmodule

// File: tb/tb_fifo_byte_packer.sv
// Self-checking bench for fifo_byte_packer: FIFO model, cycle-level reference model, directed
// and randomized stimulus. Honours PACK_MSB_FIRST_EN for the expected lane order.
module tb_fifo_byte_packer;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned NBYTES = 4;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned BC_W   = $clog2(NBYTES + 1);
   localparam int unsigned MEM    = 1024;

`ifdef PACK_MSB_FIRST_EN
   localparam logic [31:0] W_0104 = 32'h01020304;
   localparam logic [31:0] W_1114 = 32'h11121314;
   localparam logic [31:0] W_1518 = 32'h15161718;
   localparam logic [31:0] W_AADD = 32'hAABBCCDD;
`else
   localparam logic [31:0] W_0104 = 32'h04030201;
   localparam logic [31:0] W_1114 = 32'h14131211;
   localparam logic [31:0] W_1518 = 32'h18171615;
   localparam logic [31:0] W_AADD = 32'hDDCCBBAA;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fifo_byte_packer_if #(.DATA_W(DATA_W), .NBYTES(NBYTES)) bus ();
   logic [BC_W-1:0]  byte_cnt;
   logic [CNT_W-1:0] word_cnt;

   fifo_byte_packer #(.DATA_W(DATA_W), .NBYTES(NBYTES), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus.master),
      .byte_cnt (byte_cnt),
      .word_cnt (word_cnt)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // FIFO model: stimulus memory written by the driver, read pointer owned by the FIFO process.
   logic [7:0] src_mem [MEM];
   int src_wr = 0;
   int src_rd = 0;
   int pops = 0;
   int cyc = 0;

   assign bus.fifo_empty = (src_rd == src_wr);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst_n) begin
         src_rd <= src_wr;
      end else if (bus.fifo_rd_en) begin
         bus.fifo_rd_data <= src_mem[src_rd % MEM];
         src_rd <= src_rd + 1;
         pops <= pops + 1;
      end
   end

   logic rdy = 1'b1;
   logic rnd_rdy = 1'b1;
   logic rand_mode = 1'b0;
   always @(posedge clk) rnd_rdy <= 1'($urandom_range(0, 1));
   assign bus.out_ready = rand_mode ? rnd_rdy : rdy;

   function automatic logic [31:0] pack(input int idx);
      logic [31:0] w;
      w = '0;
      for (int i = 0; i < NBYTES; i++) begin
`ifdef PACK_MSB_FIRST_EN
         w[8*(NBYTES-1-i) +: 8] = src_mem[(idx + i) % MEM];
`else
         w[8*i +: 8] = src_mem[(idx + i) % MEM];
`endif
      end
      return w;
   endfunction

   // Reference model: bytes requested / captured for the current word, words handed off.
   logic [31:0] last_word = '0;
   initial begin
      int iss_m, cap_m, exp_wc, exp_rd, base, last_rd_cyc;
      bit exp_valid, prev_valid, prev_hs, hs;
      logic [31:0] prev_data;
      iss_m = 0; cap_m = 0; exp_wc = 0; exp_rd = 0; base = 0; last_rd_cyc = 0;
      prev_valid = 0; prev_hs = 0; prev_data = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            iss_m = 0; cap_m = 0; exp_wc = 0; exp_rd = src_wr; base = pops;
            prev_valid = 0; prev_hs = 0;
         end else begin
            exp_valid = (cap_m == NBYTES);
            check("out_valid", bus.out_valid, exp_valid);
            check("byte_cnt", byte_cnt, cap_m);
            check("word_cnt", word_cnt, exp_wc);
            check("rd_en", bus.fifo_rd_en, (src_rd != src_wr) && (iss_m < NBYTES));
            if (bus.out_valid && prev_valid && !prev_hs) check("hold_data", bus.out_data, prev_data);
            if (exp_valid && !prev_valid) check("latency", cyc - last_rd_cyc, 2);
            hs = exp_valid && bus.out_ready;
            if (hs) begin
               check("word", bus.out_data, pack(exp_rd));
               check("reads_per_word", pops - base, NBYTES);
               exp_rd += NBYTES;
               base = pops;
               last_word = bus.out_data;
               exp_wc = (exp_wc + 1) % (1 << CNT_W);
               iss_m = 0;
               cap_m = 0;
            end else begin
               cap_m = iss_m;
               if (bus.fifo_rd_en) begin
                  iss_m++;
                  if (iss_m == NBYTES) last_rd_cyc = cyc;
               end
            end
            prev_valid = bus.out_valid;
            prev_data = bus.out_data;
            prev_hs = hs;
         end
      end
   end

   task automatic push(input logic [7:0] b);
      src_mem[src_wr % MEM] = b;
      src_wr++;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_words(input int target, input int budget);
      int n = 0;
      while (int'(word_cnt) != target && n < budget) begin
         tick();
         n++;
      end
      check("wait_words", word_cnt, target);
   endtask

   initial begin
      int n, pops0;
      repeat (2) @(posedge clk);
      #2;
      check("rst_valid", bus.out_valid, 0);
      check("rst_data", bus.out_data, 0);
      check("rst_byte_cnt", byte_cnt, 0);
      check("rst_word_cnt", word_cnt, 0);
      check("rst_rd_en", bus.fifo_rd_en, 0);
      rst_n = 1'b1;

      // Single word, ready held high.
      tick();
      for (int i = 1; i <= 4; i++) push(8'(i));
      wait_words(1, 50);
      check("t1_word", last_word, W_0104);

      // Two words with downstream back-pressure.
      rdy = 1'b0;
      for (int i = 8'h11; i <= 8'h18; i++) push(8'(i));
      repeat (12) tick();
      check("t2_valid", bus.out_valid, 1);
      check("t2_hold", bus.out_data, W_1114);
      check("t2_rd_en", bus.fifo_rd_en, 0);
      rdy = 1'b1;
      wait_words(3, 60);
      check("t2_word2", last_word, W_1518);

      // FIFO runs dry mid-word.
      push(8'hAA);
      push(8'hBB);
      repeat (7) tick();
      check("t3_byte_cnt", byte_cnt, 2);
      check("t3_rd_en", bus.fifo_rd_en, 0);
      push(8'hCC);
      push(8'hDD);
      wait_words(4, 50);
      check("t3_word", last_word, W_AADD);

      // Reset with a partial word captured.
      for (int i = 1; i <= 3; i++) push(8'(i));
      n = 0;
      while (byte_cnt != 3 && n < 50) begin
         tick();
         n++;
      end
      check("t4_pre_byte_cnt", byte_cnt, 3);
      rst_n = 1'b0;
      #1;
      check("t4_valid", bus.out_valid, 0);
      check("t4_data", bus.out_data, 0);
      check("t4_byte_cnt", byte_cnt, 0);
      check("t4_word_cnt", word_cnt, 0);
      check("t4_rd_en", bus.fifo_rd_en, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      for (int i = 1; i <= 4; i++) push(8'(i));
      wait_words(1, 50);
      check("t4_word", last_word, W_0104);

      // Random bytes, gaps and back-pressure until word_cnt wraps to 0.
      pops0 = pops;
      rand_mode = 1'b1;
      for (int i = 0; i < 15 * NBYTES; i++) begin
         repeat ($urandom_range(0, 3)) tick();
         push(8'($urandom));
      end
      wait_words(0, 600);
      repeat (8) tick();
      check("t5_wrap", word_cnt, 0);
      check("t5_total_reads", pops - pops0, 15 * NBYTES);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
